// File: rtl/pe_conv_sequencer_if.sv
// pe_conv_sequencer_if: result stream from the convolution sequencer.
// The master presents finished window sums, the slave accepts them with a
// valid/ready handshake.
interface pe_conv_sequencer_if #(
    parameter int ACC_W = 16
) ();
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/pe_conv_sequencer.sv
// pe_conv_sequencer: drives one multiply-accumulate PE through a valid-mode
// 2-D convolution. For each output window it issues K*K buffer reads, enables
// the PE one cycle later, feeds the PE its own result back as the partial
// sum, then hands the finished sum out over a valid/ready stream.
// Optional build macro: PE_SEQ_STALL_CNT_EN adds a saturating counter of
// cycles spent waiting on the consumer (stall_cycles); without it that port
// is tied to zero.
module pe_conv_sequencer #(
    parameter  int IMAGE_PIXEL_WIDTH  = 8,
    parameter  int KERNEL_PIXEL_WIDTH = 8,
    parameter  int IMAGE_SIZE         = 32,
    parameter  int KERNEL_SIZE        = 5,
    localparam int ACC_W              = IMAGE_PIXEL_WIDTH + KERNEL_PIXEL_WIDTH,
    localparam int IMG_AW             = $clog2(IMAGE_SIZE * IMAGE_SIZE),
    localparam int KER_AW             = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE * KERNEL_SIZE) : 1
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  img_rd_en,
    output logic [IMG_AW-1:0]     img_addr,
    output logic                  ker_rd_en,
    output logic [KER_AW-1:0]     ker_addr,
    output logic                  pe_en,
    output logic [ACC_W-1:0]      pe_part_sum,
    input  logic [ACC_W-1:0]      pe_data_out,
    pe_conv_sequencer_if.master   out_if,
    output logic [15:0]           stall_cycles
);

    // Window/kernel coordinates share one width wide enough for 0..N.
    localparam int CW = $clog2(IMAGE_SIZE + 1);
    localparam int TW = $clog2(KERNEL_SIZE * KERNEL_SIZE + 1);

    localparam logic [CW-1:0] K_LAST   = CW'(KERNEL_SIZE - 1);
    localparam logic [CW-1:0] W_LAST   = CW'(IMAGE_SIZE - KERNEL_SIZE);
    localparam logic [TW-1:0] TAP_LAST = TW'(KERNEL_SIZE * KERNEL_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        OUT
    } state_t;

    state_t          state;
    logic [CW-1:0]   orow;
    logic [CW-1:0]   ocol;
    logic [CW-1:0]   kr;
    logic [CW-1:0]   kc;
    logic [TW-1:0]   tap;
    logic            tap0_d;
    logic            out_valid_q;

    logic [CW-1:0]     kr_nxt;
    logic [CW-1:0]     kc_nxt;
    logic [CW-1:0]     orow_nxt;
    logic [CW-1:0]     ocol_nxt;
    logic [IMG_AW-1:0] tap_addr_nxt;
    logic [IMG_AW-1:0] win_addr_nxt;
    logic              last_win;

    // Next tap position within the window and next window position in the image.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        kc_nxt   = kc + CW'(1);
        kr_nxt   = kr;
        ocol_nxt = ocol + CW'(1);
        orow_nxt = orow;
        if (kc == K_LAST) begin
            kc_nxt = '0;
            kr_nxt = kr + CW'(1);
        end
        if (ocol == W_LAST) begin
            ocol_nxt = '0;
            orow_nxt = orow + CW'(1);
        end
        tap_addr_nxt = IMG_AW'((int'(orow) + int'(kr_nxt)) * IMAGE_SIZE + int'(ocol) + int'(kc_nxt));
        win_addr_nxt = IMG_AW'(int'(orow_nxt) * IMAGE_SIZE + int'(ocol_nxt));
        last_win     = (orow == W_LAST) && (ocol == W_LAST);
    end

    // Sequencer FSM: tap issue, PE enable one cycle behind, result handshake.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            orow        <= '0;
            ocol        <= '0;
            kr          <= '0;
            kc          <= '0;
            tap         <= '0;
            tap0_d      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            img_rd_en   <= 1'b0;
            img_addr    <= '0;
            ker_rd_en   <= 1'b0;
            ker_addr    <= '0;
            pe_en       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
            // Read data returns one cycle after issue, so the PE consumes tap i one cycle later.
            pe_en  <= (state == RUN);
            tap0_d <= (state == RUN) && (tap == '0);
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        kr        <= '0;
                        kc        <= '0;
                        tap       <= '0;
                        img_rd_en <= 1'b1;
                        ker_rd_en <= 1'b1;
                        img_addr  <= '0;
                        ker_addr  <= '0;
                    end
                end
                RUN: begin
                    if (tap == TAP_LAST) begin
                        state     <= DRAIN;
                        img_rd_en <= 1'b0;
                        ker_rd_en <= 1'b0;
                    end else begin
                        tap      <= tap + TW'(1);
                        kr       <= kr_nxt;
                        kc       <= kc_nxt;
                        img_addr <= tap_addr_nxt;
                        ker_addr <= KER_AW'(tap + TW'(1));
                    end
                end
                DRAIN: begin
                    state       <= OUT;
                    out_valid_q <= 1'b1;
                end
                OUT: begin
                    if (out_if.out_ready) begin
                        out_valid_q <= 1'b0;
                        tap         <= '0;
                        kr          <= '0;
                        kc          <= '0;
                        if (last_win) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            orow  <= '0;
                            ocol  <= '0;
                        end else begin
                            state     <= RUN;
                            orow      <= orow_nxt;
                            ocol      <= ocol_nxt;
                            img_rd_en <= 1'b1;
                            ker_rd_en <= 1'b1;
                            img_addr  <= win_addr_nxt;
                            ker_addr  <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Close the accumulation loop: tap 0 starts from zero, later taps add to the PE result.
    assign pe_part_sum = (pe_en && !tap0_d) ? pe_data_out : '0;

    // The PE holds its value while pe_en is low, so the result is stable throughout OUT.
    assign out_if.out_valid = out_valid_q;
    assign out_if.out_data  = out_valid_q ? pe_data_out : '0;

`ifdef PE_SEQ_STALL_CNT_EN
    logic [15:0] stall_q;

    // Count OUT cycles the consumer refused; saturate, restart with each image.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if ((state == IDLE) && start) begin
            stall_q <= '0;
        end else if ((state == OUT) && !out_if.out_ready && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pe_conv_sequencer.sv
// tb_pe_conv_sequencer: directed tests for pe_conv_sequencer with N=4, K=2.
// Buffer and PE models sit around the DUT; expected results are pushed into
// a scoreboard queue and a monitor pops them on each output handshake.
module tb_pe_conv_sequencer;
    localparam int IPW    = 8;
    localparam int KPW    = 8;
    localparam int N      = 4;
    localparam int K      = 2;
    localparam int ACC_W  = IPW + KPW;
    localparam int IMG_AW = 4;
    localparam int KER_AW = 2;
    localparam int NOUT   = (N - K + 1) * (N - K + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              busy;
    logic              done;
    logic              img_rd_en;
    logic [IMG_AW-1:0] img_addr;
    logic              ker_rd_en;
    logic [KER_AW-1:0] ker_addr;
    logic              pe_en;
    logic [ACC_W-1:0]  pe_part_sum;
    logic [ACC_W-1:0]  pe_data_out;
    logic [15:0]       stall_cycles;

    pe_conv_sequencer_if #(.ACC_W(ACC_W)) out_if ();

    pe_conv_sequencer #(
        .IMAGE_PIXEL_WIDTH (IPW),
        .KERNEL_PIXEL_WIDTH(KPW),
        .IMAGE_SIZE        (N),
        .KERNEL_SIZE       (K)
    ) dut (
        .clock       (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .img_rd_en   (img_rd_en),
        .img_addr    (img_addr),
        .ker_rd_en   (ker_rd_en),
        .ker_addr    (ker_addr),
        .pe_en       (pe_en),
        .pe_part_sum (pe_part_sum),
        .pe_data_out (pe_data_out),
        .out_if      (out_if),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // Buffer models: synchronous read, one cycle latency.
    logic [IPW-1:0] img_mem [N*N];
    logic [KPW-1:0] ker_mem [K*K];
    logic [IPW-1:0] img_q = '0;
    logic [KPW-1:0] ker_q = '0;

    always @(posedge clk) begin
        if (img_rd_en) img_q <= img_mem[img_addr];
        if (ker_rd_en) ker_q <= ker_mem[ker_addr];
    end

    // PE model: registered multiply-accumulate, holds while en is low.
    always @(posedge clk or posedge rst) begin
        if (rst) pe_data_out <= '0;
        else if (pe_en) pe_data_out <= pe_part_sum + {8'd0, img_q} * {8'd0, ker_q};
    end

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    logic [ACC_W-1:0] sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every accepted output against the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_if.out_valid && out_if.out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL out_data: got %0d with nothing expected (t=%0t)", out_if.out_data, $time);
                end else begin
                    check("out_data", out_if.out_data, sb.pop_front());
                end
            end
            if (done) done_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle; returns in cycle 1 of the run.
    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Advance until done, counting cycles from acceptance (cycle c0 on entry).
    task automatic wait_done(input string name, input int c0, output int cyc);
        cyc = c0;
        while (!done && cyc < 400) begin
            step();
            cyc++;
        end
        check({name, "_done_seen"}, done, 1);
        check({name, "_busy_at_done"}, busy, 0);
    endtask

    task automatic fill(input logic [IPW-1:0] iv, input logic [KPW-1:0] kv);
        for (int a = 0; a < N*N; a++) img_mem[a] = iv;
        for (int a = 0; a < K*K; a++) ker_mem[a] = kv;
    endtask

    task automatic load_ramp(input logic [KPW-1:0] k0, k1, k2, k3);
        for (int a = 0; a < N*N; a++) img_mem[a] = IPW'(a);
        ker_mem[0] = k0;
        ker_mem[1] = k1;
        ker_mem[2] = k2;
        ker_mem[3] = k3;
    endtask

    // First-window timeline for N=4, K=2 at window (0,0), cycles 1..7.
    int tl_rd   [7] = '{1, 1, 1, 1, 0, 0, 1};
    int tl_iaddr[7] = '{0, 1, 4, 5, 0, 0, 1};
    int tl_kaddr[7] = '{0, 1, 2, 3, 0, 0, 0};
    int tl_pe   [7] = '{0, 1, 1, 1, 1, 0, 0};
    int tl_ov   [7] = '{0, 0, 0, 0, 0, 1, 0};

    int delta_exp[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    int k1234_exp[9] = '{34, 44, 54, 74, 84, 94, 114, 124, 134};

    int cyc;
    int d0;

    initial begin
        out_if.out_ready = 1'b1;
        fill(8'd0, 8'd0);
        repeat (2) step();

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_img_rd_en", img_rd_en, 0);
        check("rst_ker_rd_en", ker_rd_en, 0);
        check("rst_pe_en", pe_en, 0);
        check("rst_out_valid", out_if.out_valid, 0);
        check("rst_stall", stall_cycles, 0);
        rst = 1'b0;
        step();

        // All ones: nine outputs of 4, done 55 cycles after acceptance
        fill(8'd1, 8'd1);
        for (int i = 0; i < NOUT; i++) sb.push_back(16'd4);
        d0 = done_cnt;
        do_start();
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            check($sformatf("tl%0d_busy", c + 1), busy, 1);
            check($sformatf("tl%0d_img_rd_en", c + 1), img_rd_en, tl_rd[c]);
            check($sformatf("tl%0d_ker_rd_en", c + 1), ker_rd_en, tl_rd[c]);
            if (tl_rd[c] != 0) begin
                check($sformatf("tl%0d_img_addr", c + 1), img_addr, tl_iaddr[c]);
                check($sformatf("tl%0d_ker_addr", c + 1), ker_addr, tl_kaddr[c]);
            end
            check($sformatf("tl%0d_pe_en", c + 1), pe_en, tl_pe[c]);
            check($sformatf("tl%0d_out_valid", c + 1), out_if.out_valid, tl_ov[c]);
            if (c == 1) check("tap0_part_sum", pe_part_sum, 0);
            if (c == 2) check("tap1_part_sum", pe_part_sum, 1);
            step();
        end
        wait_done("ones", 8, cyc);
        check("ones_done_cycle", cyc, 55);
        step();
        check("ones_done_pulse", done, 0);
        check("ones_done_count", done_cnt - d0, 1);
        check("ones_sb_empty", sb.size(), 0);

        // Ramp image with delta kernel
        load_ramp(8'd1, 8'd0, 8'd0, 8'd0);
        for (int i = 0; i < NOUT; i++) sb.push_back(ACC_W'(delta_exp[i]));
        d0 = done_cnt;
        do_start();
        wait_done("delta", 1, cyc);
        step();
        check("delta_done_count", done_cnt - d0, 1);
        check("delta_sb_empty", sb.size(), 0);

        // Backpressure on the first output, ramp image with kernel {1,2,3,4}
        load_ramp(8'd1, 8'd2, 8'd3, 8'd4);
        for (int i = 0; i < NOUT; i++) sb.push_back(ACC_W'(k1234_exp[i]));
        d0 = done_cnt;
        out_if.out_ready = 1'b0;
        do_start();
        cyc = 1;
        while (!out_if.out_valid && cyc < 50) begin
            step();
            cyc++;
        end
        check("bp_valid_seen", out_if.out_valid, 1);
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            check("bp_out_valid", out_if.out_valid, 1);
            check("bp_out_data", out_if.out_data, 34);
            check("bp_pe_en", pe_en, 0);
            check("bp_img_rd_en", img_rd_en, 0);
            check("bp_ker_rd_en", ker_rd_en, 0);
            step();
        end
`ifdef PE_SEQ_STALL_CNT_EN
        check("bp_stall_cycles", stall_cycles, 10);
`else
        check("bp_stall_cycles", stall_cycles, 0);
`endif
        out_if.out_ready = 1'b1;
        wait_done("bp", 1, cyc);
        step();
        check("bp_done_count", done_cnt - d0, 1);
        check("bp_sb_empty", sb.size(), 0);

        // Accumulator wrap with start pulses while busy: 4*255*255 mod 2^16
        fill(8'd255, 8'd255);
        for (int i = 0; i < NOUT; i++) sb.push_back(16'd63492);
        d0 = done_cnt;
        do_start();
        check("wrap_stall_cleared", stall_cycles, 0);
        cyc = 1;
        while (!done && cyc < 400) begin
            start = (cyc == 2) || (cyc == 6) || (cyc == 30) || (cyc == 54);
            step();
            cyc++;
        end
        start = 1'b0;
        check("wrap_done_seen", done, 1);
        check("wrap_done_cycle", cyc, 55);
        repeat (3) step();
        check("wrap_idle_after", busy, 0);
        check("wrap_done_count", done_cnt - d0, 1);
        check("wrap_sb_empty", sb.size(), 0);

        // Reset during RUN of window 3, then a clean restart
        load_ramp(8'd1, 8'd0, 8'd0, 8'd0);
        for (int i = 0; i < 3; i++) sb.push_back(ACC_W'(delta_exp[i]));
        do_start();
        repeat (19) step();
        check("mid_busy", busy, 1);
        check("mid_img_rd_en", img_rd_en, 1);
        rst = 1'b1;
        #1;
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_img_rd_en", img_rd_en, 0);
        check("mrst_img_addr", img_addr, 0);
        check("mrst_ker_rd_en", ker_rd_en, 0);
        check("mrst_ker_addr", ker_addr, 0);
        check("mrst_pe_en", pe_en, 0);
        check("mrst_part_sum", pe_part_sum, 0);
        check("mrst_out_valid", out_if.out_valid, 0);
        check("mrst_out_data", out_if.out_data, 0);
        check("mrst_stall", stall_cycles, 0);
        check("mrst_sb_empty", sb.size(), 0);
        step();
        rst = 1'b0;
        step();
        for (int i = 0; i < NOUT; i++) sb.push_back(ACC_W'(delta_exp[i]));
        d0 = done_cnt;
        do_start();
        wait_done("restart", 1, cyc);
        check("restart_done_cycle", cyc, 55);
        step();
        check("restart_done_count", done_cnt - d0, 1);
        check("restart_sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
